// File: rtl/detector_pulsacion_if.sv
// Button-event bus: debounced button level in, registered event pulses and press count out.
interface detector_pulsacion_if;
   logic       btn;
   logic       pulso_press;
   logic       pulso_suelta;
   logic       pulso_corto;
   logic       pulso_largo;
   logic       pulso_rep;
   logic       presionado;
   logic [7:0] pulsaciones;

   modport master (
      output btn,
      input  pulso_press, pulso_suelta, pulso_corto, pulso_largo, pulso_rep,
      input  presionado, pulsaciones
   );

   modport slave (
      input  btn,
      output pulso_press, pulso_suelta, pulso_corto, pulso_largo, pulso_rep,
      output presionado, pulsaciones
   );
endinterface

// File: rtl/detector_pulsacion.sv
// Button press classifier: press/release/short/long/auto-repeat pulses, all registered.
// One edge from btn to pulse; btn has no backpressure, every event is reported once.
module detector_pulsacion #(
   parameter int LARGO   = 50000000,
   parameter int REPETIR = 10000000,
   parameter int ANCHO   = 26
) (
   input  logic                 clk,
   input  logic                 rst,
   detector_pulsacion_if.slave  bus
);
   typedef enum logic [1:0] {
      REPOSO     = 2'd0,
      PRESIONADO = 2'd1,
      REPETICION = 2'd2
   } estado_t;

   localparam logic [ANCHO-1:0] LIM_LARGO = ANCHO'(LARGO - 1);
   localparam logic [ANCHO-1:0] LIM_REP   = (REPETIR == 0) ? '0 : ANCHO'(REPETIR - 1);
   localparam bit               REP_ON    = (REPETIR != 0);

   estado_t          estado, estado_sig;
   logic [ANCHO-1:0] contador, contador_sig;
   logic [7:0]       cuenta, cuenta_sig;
   logic             press_sig, suelta_sig, corto_sig, largo_sig, rep_sig;

   always_comb begin
      estado_sig   = estado;
      contador_sig = contador;
      cuenta_sig   = cuenta;
      press_sig    = 1'b0;
      suelta_sig   = 1'b0;
      corto_sig    = 1'b0;
      largo_sig    = 1'b0;
      rep_sig      = 1'b0;
      case (estado)
         REPOSO: begin
            contador_sig = '0;
            if (bus.btn) begin
               estado_sig = PRESIONADO;
               press_sig  = 1'b1;
               cuenta_sig = cuenta + 8'd1;
            end
         end
         PRESIONADO: begin
            // Release is checked first so a release on the threshold edge is still a short press.
            if (!bus.btn) begin
               estado_sig   = REPOSO;
               contador_sig = '0;
               suelta_sig   = 1'b1;
               corto_sig    = 1'b1;
            end else if (contador == LIM_LARGO) begin
               estado_sig   = REPETICION;
               contador_sig = '0;
               largo_sig    = 1'b1;
            end else begin
               contador_sig = contador + ANCHO'(1);
            end
         end
         REPETICION: begin
            if (!bus.btn) begin
               estado_sig   = REPOSO;
               contador_sig = '0;
               suelta_sig   = 1'b1;
            end else if (!REP_ON) begin
               contador_sig = '0;
            end else if (contador == LIM_REP) begin
               contador_sig = '0;
               rep_sig      = 1'b1;
            end else begin
               contador_sig = contador + ANCHO'(1);
            end
         end
         default: begin
            estado_sig   = REPOSO;
            contador_sig = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         estado           <= REPOSO;
         contador         <= '0;
         cuenta           <= 8'd0;
         bus.pulso_press  <= 1'b0;
         bus.pulso_suelta <= 1'b0;
         bus.pulso_corto  <= 1'b0;
         bus.pulso_largo  <= 1'b0;
         bus.pulso_rep    <= 1'b0;
         bus.presionado   <= 1'b0;
      end else begin
         estado           <= estado_sig;
         contador         <= contador_sig;
         cuenta           <= cuenta_sig;
         bus.pulso_press  <= press_sig;
         bus.pulso_suelta <= suelta_sig;
         bus.pulso_corto  <= corto_sig;
         bus.pulso_largo  <= largo_sig;
         bus.pulso_rep    <= rep_sig;
         bus.presionado   <= (estado_sig != REPOSO);
      end
   end

   assign bus.pulsaciones = cuenta;
endmodule

// File: tb/tb_detector_pulsacion.sv
// Directed bench: LARGO=10 with REPETIR=4 and REPETIR=0 instances driven by the same button.
module tb_detector_pulsacion;
   logic clk;
   logic rst;
   int   n_chk;
   int   n_pass;

   detector_pulsacion_if a ();
   detector_pulsacion_if z ();

   detector_pulsacion #(.LARGO(10), .REPETIR(4), .ANCHO(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (a.slave)
   );

   detector_pulsacion #(.LARGO(10), .REPETIR(0), .ANCHO(8)) dut0 (
      .clk (clk),
      .rst (rst),
      .bus (z.slave)
   );

   // {press, suelta, corto, largo, rep}
   logic [4:0] p1, p0;
   assign p1 = {a.pulso_press, a.pulso_suelta, a.pulso_corto, a.pulso_largo, a.pulso_rep};
   assign p0 = {z.pulso_press, z.pulso_suelta, z.pulso_corto, z.pulso_largo, z.pulso_rep};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
   endtask

   task automatic tick(input logic b);
      a.btn = b;
      z.btn = b;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [4:0] exp;
      int nl1, nr1, nl0, nr0;
      n_chk  = 0;
      n_pass = 0;
      a.btn  = 1'b0;
      z.btn  = 1'b0;
      rst    = 1'b1;
      #1;
      chk("rst_async_p", p1, 0);
      chk("rst_async_cnt", a.pulsaciones, 0);
      repeat (3) tick(0);
      chk("rst_p", p1, 0);
      chk("rst_p0", p0, 0);
      chk("rst_lvl", a.presionado, 0);
      rst = 1'b0;
      tick(0);
      chk("post_rst_p", p1, 0);
      chk("post_rst_lvl", a.presionado, 0);

      // Held press through long threshold and two repeats
      for (int e = 0; e < 20; e++) begin
         tick(1);
         exp = (e == 0) ? 5'b10000 : (e == 10) ? 5'b00010 :
               (e == 14 || e == 18) ? 5'b00001 : 5'b00000;
         chk("hold_p", p1, exp);
         chk("hold_p0", p0, exp & 5'b11110);
         chk("hold_lvl", a.presionado, 1);
      end
      tick(0);
      chk("hold_rel_p", p1, 5'b01000);
      chk("hold_rel_p0", p0, 5'b01000);
      chk("hold_rel_lvl", a.presionado, 0);
      chk("hold_cnt", a.pulsaciones, 1);
      tick(0);
      chk("idle_p", p1, 0);

      // Short press
      tick(1); chk("short_press", p1, 5'b10000);
      tick(1); chk("short_1", p1, 0);
      tick(1); chk("short_2", p1, 0);
      tick(0); chk("short_rel", p1, 5'b01100);
      chk("short_cnt", a.pulsaciones, 2);

      // Release on the threshold edge
      for (int e = 0; e < 10; e++) begin
         tick(1);
         chk("coll_p", p1, (e == 0) ? 5'b10000 : 5'b00000);
      end
      tick(0);
      chk("coll_rel", p1, 5'b01100);
      chk("coll_rel0", p0, 5'b01100);
      chk("coll_cnt", a.pulsaciones, 3);
      tick(0);

      // Reset while repeating
      for (int e = 0; e <= 12; e++) begin
         tick(1);
         exp = (e == 0) ? 5'b10000 : (e == 10) ? 5'b00010 : 5'b00000;
         chk("rrep_p", p1, exp);
      end
      #2 rst = 1'b1;
      #1;
      chk("rrep_async_p", p1, 0);
      chk("rrep_async_lvl", a.presionado, 0);
      chk("rrep_async_cnt", a.pulsaciones, 0);
      tick(1);
      chk("rrep_hold_p", p1, 0);
      chk("rrep_hold_lvl", a.presionado, 0);
      #2 rst = 1'b0;
      @(posedge clk);
      #1;
      chk("rrep_press", p1, 5'b10000);
      chk("rrep_cnt", a.pulsaciones, 1);
      tick(0);
      chk("rrep_rel", p1, 5'b01100);

      // Counter wrap from a clean reset
      #2 rst = 1'b1;
      tick(0);
      #2 rst = 1'b0;
      tick(0);
      chk("wrap_start", a.pulsaciones, 0);
      for (int k = 1; k <= 256; k++) begin
         tick(1);
         chk("wrap_press", p1, 5'b10000);
         if (k == 255) chk("wrap_255", a.pulsaciones, 255);
         if (k == 256) chk("wrap_256", a.pulsaciones, 0);
         tick(0);
         chk("wrap_rel", p1, 5'b01100);
      end
      chk("wrap_cnt0", z.pulsaciones, 0);

      // 30-cycle hold: repeat disabled versus enabled
      nl1 = 0; nr1 = 0; nl0 = 0; nr0 = 0;
      for (int e = 0; e < 30; e++) begin
         tick(1);
         nl1 += int'(a.pulso_largo);
         nr1 += int'(a.pulso_rep);
         nl0 += int'(z.pulso_largo);
         nr0 += int'(z.pulso_rep);
      end
      chk("norep_largo0", nl0, 1);
      chk("norep_rep0", nr0, 0);
      chk("norep_largo1", nl1, 1);
      chk("norep_rep1", nr1, 4);
      tick(0);
      chk("norep_rel0", p0, 5'b01000);
      chk("norep_rel1", p1, 5'b01000);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/detector_pulsacion.md
DETECTOR_PULSACION -- requirements
Module: detector_pulsacion

Interface
REQ-001 Parameter LARGO, default 50000000, meaning clock cycles a press is held before it counts as a long press; legal range 2..2^ANCHO-1.
REQ-002 Parameter REPETIR, default 10000000, meaning clock cycles between auto-repeat pulses after a long press; 0 disables repeat; legal range 0..2^ANCHO-1.
REQ-003 Parameter ANCHO, default 26, meaning width of the internal hold counter.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 btn  input  1  debounced button level (1 = pressed), already synchronous to clk.
REQ-007 pulso_press  output  1  one-cycle pulse on press.
REQ-008 pulso_suelta  output  1  one-cycle pulse on release.
REQ-009 pulso_corto  output  1  one-cycle pulse on release of a press that never reached long.
REQ-010 pulso_largo  output  1  one-cycle pulse when the hold reaches LARGO.
REQ-011 pulso_rep  output  1  one-cycle auto-repeat pulse.
REQ-012 presionado  output  1  level, high while FSM is not in REPOSO.
REQ-013 pulsaciones  output  8  count of press events, wraps.

Function
REQ-014 FSM states SHALL be REPOSO, PRESIONADO and REPETICION; a 2-bit encoding is permitted.
REQ-015 All outputs SHALL be registered, and every pulso_* SHALL be high for exactly one cycle per event.
REQ-016 REPOSO, btn=1 at edge N: next state PRESIONADO, contador<=0, pulso_press=1 and pulsaciones+1, visible after edge N.
REQ-017 PRESIONADO, btn=1, contador!=LARGO-1: contador+1.
REQ-018 PRESIONADO, btn=1, contador==LARGO-1: pulso_largo=1, next state REPETICION, contador<=0; pulso_largo therefore follows edge N+LARGO.
REQ-019 REPETICION, btn=1, REPETIR!=0: contador+1; when contador==REPETIR-1, pulso_rep=1 and contador<=0, giving period REPETIR cycles.
REQ-020 REPETICION with REPETIR==0: contador holds 0 and pulso_rep is never asserted.
REQ-021 PRESIONADO, btn=0: pulso_suelta=1, pulso_corto=1, next state REPOSO, contador<=0.
REQ-022 REPETICION, btn=0: pulso_suelta=1, pulso_corto=0, next state REPOSO, contador<=0.
REQ-023 REPOSO, btn=0: no pulses; contador stays 0.
REQ-024 Simultaneous release and threshold: btn=0 takes priority over the threshold compare; no pulso_largo or pulso_rep is emitted on that edge.
REQ-025 A one-cycle btn high in REPOSO SHALL produce pulso_press, then pulso_suelta and pulso_corto on the following edge.
REQ-026 pulsaciones SHALL increment modulo 256 (255 -> 0 with no flag) and SHALL change only on press events.
REQ-027 presionado SHALL be 1 in the cycle pulso_press is high and 0 in the cycle pulso_suelta is high.
REQ-028 contador SHALL never exceed max(LARGO,REPETIR)-1.

Reset
REQ-029 On rst=1, regardless of clk: state REPOSO, contador=0, pulsaciones=0, and all pulso_* and presionado equal 0.
REQ-030 Reset asserted mid-press SHALL produce no pulso_suelta; after rst deasserts with btn=1, the next edge is treated as a new press (REQ-016).
REQ-031 No output SHALL glitch high during reset or on the first edge after rst deasserts while btn=0.

Verification (LARGO=10, REPETIR=4)
REQ-032 Held press: btn=1 at edges 0..19, btn=0 at edge 20 -> pulso_press after edge 0; pulso_largo after edge 10; pulso_rep after edges 14 and 18; pulso_suelta after edge 20; pulso_corto never; pulsaciones=1.
REQ-033 Short press: btn=1 at edges 0..2, 0 at edge 3 -> pulso_press after 0; pulso_suelta and pulso_corto after 3; no pulso_largo.
REQ-034 Threshold collision: btn=1 at edges 0..9, 0 at edge 10 -> pulso_suelta and pulso_corto after 10; pulso_largo never.
REQ-035 Reset in REPETICION: hold to edge 12, assert rst -> all outputs 0 immediately and pulsaciones=0; release rst with btn=1 -> pulso_press on the next edge.
REQ-036 Wrap: 256 short presses (btn 1 cycle high, 1 cycle low) -> pulsaciones reads 255 after the 255th press and 0 after the 256th.
REQ-037 REPETIR=0: hold 30 cycles -> exactly one pulso_largo and no pulso_rep.
